// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART constants, receiver state encoding and helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // Rounded clocks-per-tick divider.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clk_hz + den / 2) / den;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
// Module  : uart_rx_fifo_if
// Brief   : Read-side and status bundle between the UART receiver and consumer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          rd_en;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          rd_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overrun;
    logic                          frame_err;
    logic                          parity_err;

    modport master (
        input  rd_en,
        output rd_data, rd_valid, fifo_count, overrun, frame_err, parity_err
    );

    modport slave (
        output rd_en,
        input  rd_data, rd_valid, fifo_count, overrun, frame_err, parity_err
    );
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count   = r_wr_ptr - r_rd_ptr;
    assign w_do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_do_wr = wr_en && (!full || w_do_rd);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Oversampled UART receiver with majority vote, FWFT FIFO and RTS.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              rx,
    output logic              rts_n,
    uart_rx_fifo_if.master    bus
);
    localparam int DIV       = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W      = $clog2(OVERSAMPLE);
    localparam int HALF      = OVERSAMPLE / 2;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int RTS_LEVEL = FIFO_DEPTH - RTS_MARGIN;

    logic                 r_rx_meta, r_rx_sync, r_rx_prev;
    logic [DIV_W-1:0]     r_div_cnt;
    rx_state_t            r_state, w_state_next;
    logic [OS_W-1:0]      r_os_cnt;
    logic                 r_samp_a, r_samp_b;
    logic [2:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_rts_n;

    logic w_tick, w_vote, w_mid, w_bit_end, w_last_stop, w_par_bad;
    logic w_clr_os, w_commit, w_frame_err, w_parity_err;
    logic w_fifo_full, w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;

    assign w_tick      = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_mid       = w_tick && (r_os_cnt == OS_W'(HALF + 1));
    assign w_bit_end   = w_tick && (r_os_cnt == OS_W'(OVERSAMPLE - 1));
    assign w_vote      = maj3(r_samp_a, r_samp_b, r_rx_sync);
    assign w_last_stop = (STOP_BITS == 1) || r_stop_cnt;
    assign w_par_bad   = (PARITY == PAR_ODD) ? ~(^r_shift ^ w_vote) : (^r_shift ^ w_vote);

    always_comb begin
        w_state_next = r_state;
        w_clr_os     = 1'b0;
        w_commit     = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr_os = 1'b1;
                if (r_rx_prev && !r_rx_sync) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_mid && w_vote)  w_state_next = ST_IDLE;
                else if (w_bit_end)   w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_cnt == 3'(DATA_BITS - 1)))
                    w_state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // Commit at mid-bit so a following start edge is never missed.
                if (w_mid) begin
                    if (!w_vote) begin
                        w_frame_err  = 1'b1;
                        w_parity_err = r_par_err;
                        w_state_next = ST_BREAK;
                    end else if (w_last_stop) begin
                        w_parity_err = r_par_err;
                        w_commit     = !r_par_err;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (!r_rx_sync)     w_clr_os     = 1'b1;
                else if (w_bit_end) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_div_cnt  <= '0;
            r_state    <= ST_IDLE;
            r_os_cnt   <= '0;
            r_samp_a   <= 1'b1;
            r_samp_b   <= 1'b1;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_err  <= 1'b0;
            r_shift    <= '0;
            r_rts_n    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            r_state   <= w_state_next;
            r_rts_n   <= (w_fifo_count >= CNT_W'(RTS_LEVEL));

            if (w_clr_os)    r_os_cnt <= '0;
            else if (w_tick) r_os_cnt <= (r_os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : r_os_cnt + OS_W'(1);

            if (w_tick && (r_os_cnt == OS_W'(HALF - 1))) r_samp_a <= r_rx_sync;
            if (w_tick && (r_os_cnt == OS_W'(HALF)))     r_samp_b <= r_rx_sync;

            if (r_state == ST_START) begin
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                r_par_err  <= 1'b0;
            end
            if (r_state == ST_DATA) begin
                if (w_mid)     r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                if (w_bit_end) r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if ((r_state == ST_PARITY) && w_mid) r_par_err  <= w_par_bad;
            if ((r_state == ST_STOP) && w_bit_end) r_stop_cnt <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (reset_n),
        .wr_en   (w_commit),
        .wr_data (r_shift),
        .rd_en   (bus.rd_en),
        .rd_data (bus.rd_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    assign rts_n          = r_rts_n;
    assign bus.rd_valid   = !w_fifo_empty;
    assign bus.fifo_count = w_fifo_count;
    assign bus.overrun    = w_commit && w_fifo_full && !bus.rd_en;
    assign bus.frame_err  = w_frame_err;
    assign bus.parity_err = w_parity_err;

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with an oversampled, majority-voted front end and configurable frame format (data bits, parity, stop bits).
- Received bytes go into an on-chip FIFO with first-word-fall-through (FWFT) read, RTS flow control and error reporting.
- Replaces the single-byte receiver feeding the LED/PMOD logic in the top level; the consumer pops bytes with a ready/valid style read.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 8, sample ticks per bit; even, >= 4.
- DATA_BITS, 8, data bits per frame; 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 4.
- RTS_MARGIN, 4, free entries left when RTS is deasserted.

Ports:
- CLK in 1: system clock; all logic on rising edge.
- reset_n in 1: asynchronous, active-low reset.
- rx in 1: serial input, idle high, asynchronous to CLK.
- rts_n out 1: 0 = sender may transmit; 1 = stop.
- rd_en in 1: pop the head entry; ignored when rd_valid = 0.
- rd_data out DATA_BITS: head entry, valid while rd_valid = 1.
- rd_valid out 1: FIFO not empty.
- fifo_count out $clog2(FIFO_DEPTH)+1: number of occupied entries.
- overrun out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- frame_err out 1: one-cycle pulse when a stop bit is sampled low.
- parity_err out 1: one-cycle pulse when the parity check fails.

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE; FIFO is emptied.
  - All pulse outputs are 0; rd_valid = 0; rd_data = 0; fifo_count = 0.
  - rts_n = 1 while reset_n = 0, then 0 on the first clock after release.
  - The rx synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser before any use.
- Tick generator:
  - DIV = round(CLK_HZ / (BAUD * OVERSAMPLE)); the default is 13, giving 104 clocks per bit.
  - A tick is a 1-clock pulse every DIV clocks and free-runs from reset.
- Sample point: majority vote of 3 consecutive ticks centred on tick OVERSAMPLE/2 of each bit (ticks 3, 4, 5 for the default).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a synchronised falling edge on rx moves to START; the tick counter is cleared.
  - START: at the mid-bit vote, 1 = false start, return to IDLE with no flags; 0 = proceed to DATA at the end of the bit.
  - DATA: shift in DATA_BITS bits, LSB first.
  - After DATA: go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: sample the bit; odd parity requires XOR(data, p) = 1; even parity requires XOR(data, p) = 0.
  - STOP: sample every stop bit.
    - Any stop bit sampled 0: pulse frame_err and go to BREAK.
    - All stop bits 1: commit the byte at the mid-point of the last stop bit, then go to IDLE (no wait for end of bit, so back-to-back frames are tolerated).
  - BREAK: wait until rx has been 1 for one full bit time, then go to IDLE.
- Commit rules:
  - Bytes with a parity or frame error are discarded; parity_err pulses at the commit point.
  - A parity-error frame whose stop bit is also 0 pulses both parity_err and frame_err.
- FIFO write: a good byte becomes visible on rd_data/rd_valid one clock after the commit cycle.
  - FIFO full and rd_en = 0: drop the byte, pulse overrun.
  - FIFO full and rd_en = 1 in the same cycle: the write is accepted and fifo_count is unchanged.
- FIFO read:
  - FWFT: rd_en with rd_valid = 1 pops; the next entry appears the following clock.
  - Simultaneous read and write on an empty FIFO: the read is ignored and the write lands.
- Pointers: binary with an extra wrap bit; full/empty are derived from pointer equality plus the wrap bit.
- RTS, registered:
  - rts_n = 1 when fifo_count >= FIFO_DEPTH - RTS_MARGIN.
  - rts_n = 0 when fifo_count < FIFO_DEPTH - RTS_MARGIN.
  - A frame already in flight when rts_n rises is still received.
- Reset asserted mid-frame: the partial byte is lost and no flags fire.

Decomposition:
- Shared package uart_pkg:
  - Parity encoding constants (PAR_NONE/ODD/EVEN).
  - rx FSM state enum.
  - Divider rounding function.
  - Majority-of-3 function.
- One natural sub-module: sync_fifo.
  - Parametrised by width and depth; FWFT; provides count, full and empty.
  - Reusable by a later uart_tx_fifo.

Test Plan:
- Single frame 0xA5 (8N1) at 104 clk/bit -> rd_valid rises one clock after the commit cycle, rd_data = 0xA5; no flags.
- 3-clock low glitch on idle rx -> FSM returns to IDLE; fifo_count stays 0; no flags.
- PARITY = 2 (even), send 0x03 with parity bit 1 -> parity_err pulses once and the byte is dropped; then 0x03 with parity bit 0 -> byte accepted.
- Stop bit driven 0, then rx held low for 20 bit times -> single frame_err pulse, FSM stays in BREAK, no bytes written; rx high for one bit time then frame 0x55 -> 0x55 received.
- 17 back-to-back frames 0x00..0x10 with no reads (FIFO_DEPTH = 16):
  - rts_n = 1 once fifo_count reaches 12.
  - overrun pulses on 0x10; reading then returns 0x00..0x0F in order.
- FIFO full and rd_en asserted on the commit cycle of the next frame -> no overrun; fifo_count stays 16; the new byte ends up last.
